seg7_decoder: RTL and testbench
===============================

Name: seg7_decoder

Overview:
- Receive side of the 7-segment display interface: samples the 7 segment lines produced by the digit-to-segments encoder, waits until they are stable, and decodes them back to a 4-bit hex digit.
- Delivers the digit over a valid/ready handshake with error and overrun flags.
- Used for loopback self-test of the J2 display header and for observing external 7-segment drivers.

Parameters:
- STABLE_CYCLES, 1024: consecutive identical synchronized samples required before a pattern is accepted; legal range 1..65535.
- CNT_W, 16: width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- seg_in  in  7  raw segment lines, active-low; seg_in[6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g
- digit  out  4  decoded hex value
- blank  out  1  accepted pattern was all segments off (7'h7F)
- err  out  1  accepted pattern is not one of the 16 legal codes and is not blank
- out_valid  out  1  digit/blank/err hold a new accepted pattern
- out_ready  in  1  consumer accepts the current output
- overrun  out  1  sticky; a new pattern replaced an unconsumed one

Behaviour:
- Reset: asserting rst clears all registers immediately, regardless of clk. Reset values:
  - digit=0, blank=0, err=0, out_valid=0, overrun=0.
  - Synchronizer flops = 7'h7F.
  - Stability counter = 0.
  - last_accepted = 7'h7F.
- Synchronization: seg_in passes through a 2-flop synchronizer (s2). All later logic uses s2 only.
- Stability tracking: a holding register cand tracks s2 each cycle.
  - If s2 != cand: cand<=s2 and cnt<=0.
  - Else, if cnt < STABLE_CYCLES: cnt<=cnt+1.
  - cnt saturates at STABLE_CYCLES; it never wraps.
- Acceptance: on the cycle cnt transitions from STABLE_CYCLES-1 to STABLE_CYCLES, the pattern in cand is accepted only if cand != last_accepted. On acceptance, last_accepted<=cand.
  - Re-stabilising to the same pattern, e.g. after a glitch, produces no output.
- Decode table (hex, active-low) for legal codes:
  - 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F
  - 8:00, 9:04, A:08, B:60, C:31, D:42, E:30, F:38
- On acceptance, on the next edge:
  - out_valid<=1.
  - Legal code: digit<=decoded value, blank<=0, err<=0.
  - 7F: digit<=0, blank<=1, err<=0.
  - Any other pattern: digit<=0, blank<=0, err<=1.
- Latency: an input change held steady reaches out_valid exactly STABLE_CYCLES+3 clk edges after it is first presented at seg_in (2 sync + STABLE_CYCLES + 1 output register).
- Handshake:
  - out_valid stays high and digit/blank/err stay frozen until a cycle with out_valid&&out_ready; out_valid drops on the following edge.
  - out_ready is ignored while out_valid=0.
- Simultaneous consume and accept: acceptance wins. New data is loaded, out_valid stays 1, overrun is not set.
- Accept while out_valid=1 and out_ready=0: new data overwrites the pending data and overrun<=1.
  - overrun clears only on rst.
- Reset during stabilisation: the counter is cleared and last_accepted returns to 7F, so a subsequent steady 7F is not reported.

Optional Feature:
- Macro SEG7_DECODER_ERRCNT_EN.
- Defined: adds output err_count[7:0].
  - Increments on every acceptance with err=1 (after reset, the first error acceptance sets it to 1).
  - Saturates at 8'hFF.
  - Reset value 0.
- Undefined: no err_count port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset with seg_in=7F, then drive 7'h12 steady, STABLE_CYCLES=4, out_ready=0 -> out_valid rises 7 edges after the change; digit=2, err=0, blank=0.
- Sweep all 16 legal codes, each held 10 cycles, out_ready=1, STABLE_CYCLES=4 -> 16 handshakes, digit values 0..F in order, overrun=0.
- Drive 7'h00 steady, then a 2-cycle glitch to 7'h01, then back to 7'h00 (STABLE_CYCLES=4) -> exactly one output (digit=8); the glitch produces nothing.
- Drive 7'h7E, then 7'h7F -> first output err=1, digit=0; second output blank=1; with SEG7_DECODER_ERRCNT_EN defined, err_count=1.
- With out_ready=0, accept 7'h4F then 7'h24 -> out_valid held, digit=5, overrun=1; later out_ready=1 pulse -> out_valid=0, overrun stays 1.
- Assert rst asynchronously (between clk edges) mid-stabilisation of 7'h06 -> all outputs 0 immediately; releasing rst with seg_in=7F produces no output.

Source files
------------

// File: rtl/seg7_decoder_if.sv
// Output bus of the 7-segment receive decoder: decoded digit, status flags and valid/ready handshake.
// SEG7_DECODER_ERRCNT_EN adds the err_count field.
interface seg7_decoder_if;
  logic [3:0] digit;
  logic       blank;
  logic       err;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
`ifdef SEG7_DECODER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  modport master (
    input  out_ready,
    output digit, blank, err, out_valid, overrun
`ifdef SEG7_DECODER_ERRCNT_EN
    , output err_count
`endif
  );

  modport slave (
    output out_ready,
    input  digit, blank, err, out_valid, overrun
`ifdef SEG7_DECODER_ERRCNT_EN
    , input err_count
`endif
  );
endinterface

// File: rtl/seg7_decoder.sv
// Receive-side 7-segment decoder: synchronizes active-low segment lines, waits for a stable
// pattern and delivers the hex digit over valid/ready. SEG7_DECODER_ERRCNT_EN adds err_count.
module seg7_decoder #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  seg7_decoder_if.master out_if
);

  localparam logic [6:0]       BLANK_CODE = 7'h7F;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  // Entry n (bits 7n+6:7n) is the active-low pattern for hex digit n.
  localparam logic [111:0] CODE_TABLE = {
    7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
    7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
  };

  logic [6:0]       sync1_q, sync2_q;
  logic [6:0]       cand_q, cand_d;
  logic [6:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       digit_q, digit_d;
  logic             blank_q, blank_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [15:0] code_hit;
  logic [3:0]  dec_digit;
  logic        dec_legal;
  logic        dec_blank;
  logic        accept;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign code_hit[gi] = (cand_q == CODE_TABLE[gi*7 +: 7]);
    end
  endgenerate

  always_comb begin
    dec_digit = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (code_hit[i]) dec_digit = 4'(i);
    end
    dec_legal = |code_hit;
    dec_blank = (cand_q == BLANK_CODE);
  end

  // Acceptance fires only on the single cycle the counter reaches saturation.
  assign accept = (sync2_q == cand_q) && (cnt_q == CNT_LAST) && (cand_q != last_q);

  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    digit_d   = digit_q;
    blank_d   = blank_q;
    err_d     = err_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (accept) begin
      last_d  = cand_q;
      valid_d = 1'b1;
      digit_d = dec_legal ? dec_digit : 4'd0;
      blank_d = dec_blank;
      err_d   = !dec_legal && !dec_blank;
      if (valid_q && !out_if.out_ready) overrun_d = 1'b1;
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= BLANK_CODE;
      sync2_q   <= BLANK_CODE;
      cand_q    <= BLANK_CODE;
      last_q    <= BLANK_CODE;
      cnt_q     <= '0;
      digit_q   <= 4'd0;
      blank_q   <= 1'b0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= seg_in;
      sync2_q   <= sync1_q;
      cand_q    <= cand_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SEG7_DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && !dec_legal && !dec_blank && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign out_if.err_count = err_cnt_q;
`endif

  assign out_if.digit     = digit_q;
  assign out_if.blank     = blank_q;
  assign out_if.err       = err_q;
  assign out_if.out_valid = valid_q;
  assign out_if.overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_decoder.sv
// Testbench for seg7_decoder: directed scenarios plus randomized segment streams checked
// every cycle against a run-length reference model of the input history.
module tb_seg7_decoder;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg_in = 7'h7F;

  seg7_decoder_if bus ();

  seg7_decoder #(.STABLE_CYCLES(S), .CNT_W(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .seg_in (seg_in),
    .out_if (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] codes [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  int tests = 0;
  int fails = 0;

  // Reference model: a pattern is reported when the raw input has held one value for
  // S+1 consecutive edges (seen two edges late through the synchronizer) and differs
  // from the last reported pattern.
  logic [6:0] hist_q [$];
  logic [6:0] m_prev, m_last;
  int         m_run;
  logic [3:0] m_digit;
  logic       m_blank, m_err, m_valid, m_overrun;
  int         m_errcnt;
  logic [3:0] hs_q [$];

  task automatic model_reset();
    hist_q    = '{7'h7F, 7'h7F};
    m_prev    = 7'h7F;
    m_run     = 1;
    m_last    = 7'h7F;
    m_digit   = 4'd0;
    m_blank   = 1'b0;
    m_err     = 1'b0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_errcnt  = 0;
  endtask

  task automatic model_edge();
    logic [6:0] v;
    logic found;
    hist_q.push_back(seg_in);
    v = hist_q.pop_front();
    if (v == m_prev) m_run++;
    else begin
      m_run  = 1;
      m_prev = v;
    end
    if (m_run == S + 1 && v != m_last) begin
      if (m_valid && !bus.out_ready) m_overrun = 1'b1;
      m_valid = 1'b1;
      m_last  = v;
      m_digit = 4'd0;
      m_blank = 1'b0;
      m_err   = 1'b0;
      found   = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (codes[i] == v) begin
          m_digit = 4'(i);
          found   = 1'b1;
        end
      end
      if (v == 7'h7F) m_blank = 1'b1;
      else if (!found) begin
        m_err = 1'b1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    check({tag, ".digit"},     32'(bus.digit),     32'(m_digit));
    check({tag, ".blank"},     32'(bus.blank),     32'(m_blank));
    check({tag, ".err"},       32'(bus.err),       32'(m_err));
    check({tag, ".overrun"},   32'(bus.overrun),   32'(m_overrun));
`ifdef SEG7_DECODER_ERRCNT_EN
    check({tag, ".err_count"}, 32'(bus.err_count), 32'(m_errcnt));
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    if (bus.out_valid && bus.out_ready) hs_q.push_back(bus.digit);
  endtask

  task automatic hold(input logic [6:0] v, input int n, input string tag);
    seg_in = v;
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    int n;
    int seen;
    logic [6:0] v;

    bus.out_ready = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    rst = 1'b0;
    hold(7'h7F, 10, "idle");

    // First pattern after reset, measuring the latency to out_valid
    seg_in = 7'h12;
    n = 0;
    do begin
      n++;
      tick("first");
    end while (!bus.out_valid && n <= 20);
    check("first.latency", 32'(n), 32'(S + 3));
    check("first.digit", 32'(bus.digit), 32'h2);
    check("first.err", 32'(bus.err), 32'h0);
    check("first.blank", 32'(bus.blank), 32'h0);

    // Sweep all legal codes with the consumer always ready
    bus.out_ready = 1'b1;
    tick("drain");
    hs_q.delete();
    for (int d = 0; d < 16; d++) hold(codes[d], 10, "sweep");
    check("sweep.count", 32'(hs_q.size()), 32'd16);
    for (int d = 0; d < 16 && d < hs_q.size(); d++) check("sweep.digit", 32'(hs_q[d]), 32'(d));
    check("sweep.overrun", 32'(bus.overrun), 32'h0);

    // Short glitch, then return to the already-reported pattern
    hs_q.delete();
    hold(7'h00, 10, "glitch");
    hold(7'h01, 2, "glitch");
    hold(7'h00, 12, "glitch");
    check("glitch.count", 32'(hs_q.size()), 32'd1);
    if (hs_q.size() > 0) check("glitch.digit", 32'(hs_q[0]), 32'h8);

    // Illegal pattern then blank
    bus.out_ready = 1'b0;
    hold(7'h7E, 10, "errblank");
    check("err.valid", 32'(bus.out_valid), 32'h1);
    check("err.err", 32'(bus.err), 32'h1);
    check("err.digit", 32'(bus.digit), 32'h0);
`ifdef SEG7_DECODER_ERRCNT_EN
    check("err.err_count", 32'(bus.err_count), 32'h1);
`endif
    bus.out_ready = 1'b1;
    tick("errblank");
    bus.out_ready = 1'b0;
    hold(7'h7F, 10, "errblank");
    check("blank.valid", 32'(bus.out_valid), 32'h1);
    check("blank.blank", 32'(bus.blank), 32'h1);
    check("blank.err", 32'(bus.err), 32'h0);
    bus.out_ready = 1'b1;
    tick("errblank");

    // Overrun: second pattern arrives before the first is consumed
    bus.out_ready = 1'b0;
    hold(7'h4F, 10, "overrun");
    check("ovr.first_digit", 32'(bus.digit), 32'h1);
    check("ovr.first_overrun", 32'(bus.overrun), 32'h0);
    hold(7'h24, 10, "overrun");
    check("ovr.valid", 32'(bus.out_valid), 32'h1);
    check("ovr.digit", 32'(bus.digit), 32'h5);
    check("ovr.overrun", 32'(bus.overrun), 32'h1);
    bus.out_ready = 1'b1;
    tick("overrun");
    bus.out_ready = 1'b0;
    check("ovr.consumed", 32'(bus.out_valid), 32'h0);
    check("ovr.sticky", 32'(bus.overrun), 32'h1);

    // Asynchronous reset in the middle of stabilisation
    hold(7'h06, 4, "arst");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("arst.immediate");
    seg_in = 7'h7F;
    #2;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick("arst");
      if (bus.out_valid) seen++;
    end
    check("arst.no_output", 32'(seen), 32'd0);

    // Randomized segment stream with a randomly stalling consumer
    for (int seg = 0; seg < 200; seg++) begin
      n = $urandom_range(0, 99);
      if (n < 60)      v = codes[$urandom_range(0, 15)];
      else if (n < 75) v = 7'h7F;
      else             v = 7'($urandom);
      seg_in = v;
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
